serial_adder_sequencer: RTL and testbench

SERIAL_ADDER_SEQUENCER -- requirements
Module: serial_adder_sequencer

---
 rtl/adder_pkg.sv | 10 +
 rtl/serial_adder_sequencer_full_adder.sv | 16 +
 rtl/serial_adder_sequencer.sv | 112 +++++++++++
 tb/tb_serial_adder_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encodings and default width for the serial adder
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_sequencer_full_adder.sv
// rtl/serial_adder_sequencer_full_adder.sv - gate-level 1-bit full adder cell
module structuralFullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic axb;

  assign axb    = a_i ^ b_i;
  assign sum_o  = axb ^ cin_i;
  assign cout_o = (a_i & b_i) | (axb & cin_i);

endmodule

// File: rtl/serial_adder_sequencer.sv
// rtl/serial_adder_sequencer.sv - LSB-first bit-serial adder, one bit per clock,
// with a valid/ready operand handshake and a held result until consumed.
module serial_adder_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  structuralFullAdder u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          carry_d   = in_cin;
          res_d     = '0;
          cnt_d     = '0;
          msb_cin_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // carry_q here is the carry into the MSB cell, needed for signed overflow
        if (cnt_q == LAST_BIT) begin
          msb_cin_d = carry_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cnt_q     <= cnt_d;
    end
  end

  // Result outputs are gated by the state so they read zero outside DONE.
  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_sum      = out_valid ? res_q : '0;
  assign out_cout     = out_valid & carry_q;
  assign out_overflow = out_valid & (msb_cin_q ^ carry_q);

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// tb/tb_serial_adder_sequencer.sv - self-checking bench for serial_adder_sequencer
module tb_serial_adder_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_cout     (out_cout),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input string tag);
    logic [W:0] exp_full;
    logic       exp_ovf;
    int         lat;
    exp_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_ovf  = (a[W-1] == b[W-1]) && (exp_full[W-1] != a[W-1]);
    chk({tag, "_idle_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    tick();
    chk({tag, "_busy"}, in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      in_valid = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_sum"}, out_sum, exp_full[W-1:0]);
    chk({tag, "_cout"}, out_cout, exp_full[W]);
    chk({tag, "_ovf"}, out_overflow, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      in_a     = W'($urandom);
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_sum"}, out_sum, exp_full[W-1:0]);
      chk({tag, "_hold_cout"}, out_cout, exp_full[W]);
      chk({tag, "_hold_ovf"}, out_overflow, exp_ovf);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_ready"}, in_ready, 1);
    chk({tag, "_rel_sum"}, out_sum, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_ovf", out_overflow, 0);
    tick();

    run_op(8'h0F, 8'h01, 1'b0, 0, "d0f_01");
    run_op(8'hFF, 8'h00, 1'b1, 1, "dff_00_c");
    run_op(8'h7F, 8'h01, 1'b0, 0, "d7f_01");
    run_op(8'h80, 8'h80, 1'b0, 5, "d80_80_hold");

    // Reset sampled at the end of the third RUN cycle
    in_valid = 1'b1;
    in_a     = 8'hA5;
    in_b     = 8'h3C;
    in_cin   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_rst_ready", in_ready, 1);
    chk("midrun_rst_valid", out_valid, 0);
    chk("midrun_rst_sum", out_sum, 0);
    chk("midrun_rst_cout", out_cout, 0);
    chk("midrun_rst_ovf", out_overflow, 0);
    run_op(8'h01, 8'h01, 1'b0, 0, "post_rst");

    // Reset while holding a result under backpressure
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_cin   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    chk("done_before_rst", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("done_rst_valid", out_valid, 0);
    chk("done_rst_ready", in_ready, 1);
    chk("done_rst_sum", out_sum, 0);
    chk("done_rst_cout", out_cout, 0);

    // Reset beats a simultaneous accept
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("prio_ready0", in_ready, 1);
    tick();
    chk("prio_ready1", in_ready, 1);
    chk("prio_valid1", out_valid, 0);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
